// File: rtl/mdr_engine.sv
// rtl/mdr_engine.sv - signed multiply / divide / square-root engine, one bit per clock
// Operands arrive on successive start pulses; results are registered and held until the next start.
module mdr_engine #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     data,
   input  logic [1:0]           op,
   output logic                 need_y,
   output logic                 busy,
   output logic                 ready,
   output logic                 error,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     remainder
);

   localparam int ITER_MD = WIDTH;
   localparam int ITER_SQ = WIDTH / 2;
   localparam int HW      = WIDTH / 2;
   localparam int CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_MD  = CW'(ITER_MD);
   localparam logic [CW-1:0] C_SQ  = CW'(ITER_SQ);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_SQR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_Y, S_CHECK, S_RUN, S_DONE, S_ERR
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_x, r_y;
   logic [1:0]           r_op;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_ma, r_mb;
   logic                 r_neg_q, r_neg_r;
   logic [WIDTH-1:0]     r_hi, r_lo;
   logic [HW-1:0]        r_root;
   logic                 r_need_y, r_busy, r_ready, r_error;
   logic [2*WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]     r_remainder;

   logic [WIDTH-1:0]     w_abs_x, w_abs_y;
   logic [WIDTH:0]       w_msum, w_dsh, w_dsub, w_ssub;
   logic [WIDTH-1:0]     w_ssh, w_strial;
   logic [WIDTH-1:0]     w_hi_n, w_lo_n;
   logic [HW-1:0]        w_root_n;
   logic [2*WIDTH-1:0]   w_mag, w_res;
   logic [WIDTH-1:0]     w_rem;
   logic                 w_bad;

   assign need_y    = r_need_y;
   assign busy      = r_busy;
   assign ready     = r_ready;
   assign error     = r_error;
   assign result    = r_result;
   assign remainder = r_remainder;

   assign w_abs_x = r_x[WIDTH-1] ? (~r_x + 1'b1) : r_x;
   assign w_abs_y = r_y[WIDTH-1] ? (~r_y + 1'b1) : r_y;
   assign w_bad   = (r_op == OP_RSV) || ((r_op == OP_DIV) && (r_y == '0)) ||
                    ((r_op == OP_SQR) && r_x[WIDTH-1]);

   // r_hi/r_lo are shared: product halves, remainder/quotient, or partial remainder/radicand.
   always_comb begin
      w_hi_n   = r_hi;
      w_lo_n   = r_lo;
      w_root_n = r_root;
      w_mag    = '0;
      w_res    = '0;
      w_rem    = '0;
      w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : {(WIDTH+1){1'b0}});
      w_dsh    = {r_hi, r_lo[WIDTH-1]};
      w_dsub   = w_dsh - {1'b0, r_mb};
      w_ssh    = {r_hi[WIDTH-3:0], r_lo[WIDTH-1:WIDTH-2]};
      w_strial = WIDTH'({r_root, 2'b01});
      w_ssub   = {1'b0, w_ssh} - {1'b0, w_strial};
      case (r_op)
         OP_MUL: begin
            w_hi_n = w_msum[WIDTH:1];
            w_lo_n = {w_msum[0], r_lo[WIDTH-1:1]};
            w_mag  = {w_hi_n, w_lo_n};
            w_res  = r_neg_q ? (~w_mag + 1'b1) : w_mag;
         end
         OP_DIV: begin
            if (!w_dsub[WIDTH]) begin
               w_hi_n = w_dsub[WIDTH-1:0];
               w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
               w_hi_n = w_dsh[WIDTH-1:0];
               w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
            end
            w_mag = {{WIDTH{1'b0}}, w_lo_n};
            w_res = r_neg_q ? (~w_mag + 1'b1) : w_mag;
            w_rem = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;
         end
         default: begin
            w_lo_n = {r_lo[WIDTH-3:0], 2'b00};
            if (!w_ssub[WIDTH]) begin
               w_hi_n   = w_ssub[WIDTH-1:0];
               w_root_n = {r_root[HW-2:0], 1'b1};
            end else begin
               w_hi_n   = w_ssh;
               w_root_n = {r_root[HW-2:0], 1'b0};
            end
            w_res = (2*WIDTH)'(w_root_n);
            w_rem = w_hi_n;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_ma        <= '0;
         r_mb        <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_root      <= '0;
         r_need_y    <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
         r_error     <= 1'b0;
         r_result    <= '0;
         r_remainder <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_x         <= data;
                  r_op        <= op;
                  r_ready     <= 1'b0;
                  r_error     <= 1'b0;
                  r_result    <= '0;
                  r_remainder <= '0;
                  if (op == OP_SQR) begin
                     r_busy  <= 1'b1;
                     r_state <= S_CHECK;
                  end else begin
                     r_need_y <= 1'b1;
                     r_state  <= S_WAIT_Y;
                  end
               end else if (r_state == S_ERR) begin
                  r_error <= 1'b1;
               end
            end
            S_WAIT_Y: begin
               if (start) begin
                  r_y      <= data;
                  r_need_y <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_bad) begin
                  r_busy  <= 1'b0;
                  r_state <= S_ERR;
               end else begin
                  r_ma    <= w_abs_x;
                  r_mb    <= w_abs_y;
                  r_neg_q <= r_x[WIDTH-1] ^ r_y[WIDTH-1];
                  r_neg_r <= r_x[WIDTH-1];
                  r_hi    <= '0;
                  r_root  <= '0;
                  r_lo    <= (r_op == OP_MUL) ? w_abs_y : w_abs_x;
                  r_cnt   <= (r_op == OP_SQR) ? C_SQ : C_MD;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_hi   <= w_hi_n;
               r_lo   <= w_lo_n;
               r_root <= w_root_n;
               r_cnt  <= r_cnt - C_ONE;
               if (r_cnt == C_ONE) begin
                  r_result    <= w_res;
                  r_remainder <= w_rem;
                  r_ready     <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdr_engine.sv
// tb/tb_mdr_engine.sv - directed self-checking bench for mdr_engine (WIDTH=16)
module tb_mdr_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data = '0;
   logic [1:0]  op = '0;
   logic        need_y, busy, ready, error;
   logic [31:0] result;
   logic [15:0] remainder;
   int          total = 0;
   int          bad = 0;
   int          n;

   mdr_engine #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .data(data), .op(op),
      .need_y(need_y), .busy(busy), .ready(ready), .error(error),
      .result(result), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle start; afterwards data/op are scrambled to prove they are only sampled on start.
   task automatic pulse(input logic [15:0] d, input logic [1:0] o);
      @(negedge clk);
      start = 1'b1;
      data  = d;
      op    = o;
      step();
      start = 1'b0;
      data  = 16'hA5A5;
      op    = 2'b11;
   endtask

   task automatic wait_ready();
      n = 0;
      while (!ready && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk(tag, {60'd0, need_y, busy, ready, error}, {60'd0, exp});
   endtask

   initial begin
      #12;
      chk_flags("reset_flags", 4'b0000);
      chk("reset_result", result, 32'h0);
      chk("reset_rem", remainder, 16'h0);
      @(negedge clk);
      rst = 1'b1;

      // multiply 300 * -25
      pulse(16'd300, 2'b00);
      chk_flags("mul_wait_y", 4'b1000);
      pulse(16'hFFE7, 2'b11);
      chk_flags("mul_busy", 4'b0100);
      wait_ready();
      chk("mul_latency", n, 17);
      chk("mul_result", result, 32'hFFFFE2B4);
      chk("mul_rem", remainder, 16'h0);
      chk_flags("mul_done_flags", 4'b0010);

      // divide -100 / 7
      pulse(16'hFF9C, 2'b01);
      pulse(16'd7, 2'b00);
      wait_ready();
      chk("div_latency", n, 17);
      chk("div_result", result, 32'hFFFFFFF2);
      chk("div_rem", remainder, 16'hFFFE);

      // divide -32768 / -1
      pulse(16'h8000, 2'b01);
      pulse(16'hFFFF, 2'b01);
      wait_ready();
      chk("div_min_result", result, 32'h00008000);
      chk("div_min_rem", remainder, 16'h0);

      // multiply -32768 * -32768
      pulse(16'h8000, 2'b00);
      pulse(16'h8000, 2'b00);
      wait_ready();
      chk("mul_min_result", result, 32'h40000000);

      // sqrt 1000, single start
      pulse(16'd1000, 2'b10);
      chk_flags("sqrt_no_need_y", 4'b0100);
      wait_ready();
      chk("sqrt_latency", n, 9);
      chk("sqrt_result", result, 32'd31);
      chk("sqrt_rem", remainder, 16'd39);

      pulse(16'd0, 2'b10);
      wait_ready();
      chk("sqrt0_latency", n, 9);
      chk("sqrt0_result", result, 32'd0);
      chk("sqrt0_rem", remainder, 16'd0);

      // error: divide by zero
      pulse(16'd5, 2'b01);
      pulse(16'd0, 2'b01);
      step();
      chk("div0_err_early", error, 1'b0);
      step();
      chk_flags("div0_flags", 4'b0001);
      chk("div0_result", result, 32'h0);

      // error: sqrt of negative
      pulse(16'hFFFC, 2'b10);
      step();
      step();
      chk_flags("sqrtneg_flags", 4'b0001);
      chk("sqrtneg_result", result, 32'h0);
      chk("sqrtneg_rem", remainder, 16'h0);

      // error: reserved op
      pulse(16'd3, 2'b11);
      pulse(16'd4, 2'b00);
      step();
      step();
      chk_flags("rsv_flags", 4'b0001);
      chk("rsv_result", result, 32'h0);

      // valid start clears error
      pulse(16'd1000, 2'b10);
      chk("err_clear", error, 1'b0);
      wait_ready();
      chk("after_err_result", result, 32'd31);

      // mul 1234 * 56 with stray starts during CHECK and RUN
      pulse(16'd1234, 2'b00);
      pulse(16'd56, 2'b00);
      pulse(16'd999, 2'b01);
      pulse(16'd7, 2'b10);
      wait_ready();
      chk("stray_latency", n, 15);
      chk("stray_result", result, 32'h00010DF0);
      chk("stray_rem", remainder, 16'h0);

      // asynchronous reset mid-RUN
      pulse(16'd100, 2'b00);
      pulse(16'd3, 2'b00);
      step();
      step();
      chk_flags("pre_reset_busy", 4'b0100);
      #2;
      rst = 1'b0;
      #1;
      chk_flags("async_reset_flags", 4'b0000);
      chk("async_reset_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      pulse(16'hFFF9, 2'b01);
      chk_flags("post_reset_wait_y", 4'b1000);
      pulse(16'd2, 2'b00);
      wait_ready();
      chk("post_reset_result", result, 32'hFFFFFFFD);
      chk("post_reset_rem", remainder, 16'hFFFF);

      // held result, then back-to-back start from DONE
      step();
      step();
      chk("done_hold", result, 32'hFFFFFFFD);
      pulse(16'd12, 2'b00);
      chk_flags("b2b_flags", 4'b1000);
      chk("b2b_cleared", result, 32'h0);
      pulse(16'hFFFD, 2'b00);
      wait_ready();
      chk("b2b_latency", n, 17);
      chk("b2b_result", result, 32'hFFFFFFDC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
